// File: rtl/fifo_word_packer.sv
// Packs PACK_RATIO FIFO words into one valid/ready beat, with flush of partial beats.
// Optional FIFO_WORD_PACKER_STATS_EN adds beat_count / partial_count counters.
module fifo_word_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int PACK_RATIO = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep,
  output logic                             out_valid,
  input  logic                             out_ready
`ifdef FIFO_WORD_PACKER_STATS_EN
  ,
  output logic [15:0]                      beat_count,
  output logic [7:0]                       partial_count
`endif
);

  localparam int BW = DATA_WIDTH * PACK_RATIO;
  localparam int CW = $clog2(PACK_RATIO + 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         lane_q, lane_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  flush_req_q, flush_req_d;
  logic [BW-1:0]         data_q, data_d;
  logic [PACK_RATIO-1:0] keep_q, keep_d;
  logic [CW:0]           fill;
  logic                  rd_en;

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    flush_req_d = flush_req_q | flush;
    data_d      = data_q;
    keep_d      = keep_q;
    rd_en       = 1'b0;
    fill        = {1'b0, lane_q} + {{CW{1'b0}}, rd_pend_q};
    unique case (state_q)
      COLLECT: begin
        rd_en = !fifo_empty && !flush_req_q &&
                (fill < (CW+1)'(PACK_RATIO));
        if (rd_pend_q) begin
          for (int i = 0; i < PACK_RATIO; i++) begin
            if (lane_q == CW'(i))
              data_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
          end
          lane_d = lane_q + 1'b1;
          if (lane_d == CW'(PACK_RATIO)) begin
            state_d = HOLD;
            keep_d  = '1;
          end
        end else if (flush_req_q) begin
          // Unfilled lanes are already zero since the buffer clears on transfer.
          flush_req_d = flush;
          if (lane_q != '0) begin
            state_d = HOLD;
            for (int i = 0; i < PACK_RATIO; i++)
              keep_d[i] = (CW'(i) < lane_q);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          rd_en   = !fifo_empty && !flush_req_q;
          state_d = COLLECT;
          lane_d  = '0;
          data_d  = '0;
          keep_d  = '0;
        end
      end
      default: ;
    endcase
    rd_pend_d = rd_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      lane_q      <= '0;
      rd_pend_q   <= 1'b0;
      flush_req_q <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      rd_pend_q   <= rd_pend_d;
      flush_req_q <= flush_req_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
    end
  end

  assign fifo_rd_en = rd_en & ~rst;
  assign out_valid  = (state_q == HOLD);
  assign out_data   = data_q;
  assign out_keep   = keep_q;

`ifdef FIFO_WORD_PACKER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count    <= '0;
      partial_count <= '0;
    end else if (out_valid && out_ready) begin
      if (beat_count != 16'hFFFF)
        beat_count <= beat_count + 1'b1;
      if (keep_q != '1 && partial_count != 8'hFF)
        partial_count <= partial_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a behavioural FIFO model.
// Stats checks are active when FIFO_WORD_PACKER_STATS_EN is defined.
module tb_fifo_word_packer;

  localparam int W = 16;
  localparam int P = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   fifo_dout = '0;
  logic           fifo_empty;
  logic           fifo_rd_en;
  logic           flush = 1'b0;
  logic [W*P-1:0] out_data;
  logic [P-1:0]   out_keep;
  logic           out_valid;
  logic           out_ready = 1'b1;
`ifdef FIFO_WORD_PACKER_STATS_EN
  logic [15:0]    beat_count;
  logic [7:0]     partial_count;
`endif

  logic [W-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int vectors = 0;
  int misses = 0;
  int underflow = 0;
  int n;
  int bad;

  fifo_word_packer #(.DATA_WIDTH(W), .PACK_RATIO(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef FIFO_WORD_PACKER_STATS_EN
    ,
    .beat_count    (beat_count),
    .partial_count (partial_count)
`endif
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (wr_ptr == rd_ptr) underflow <= underflow + 1;
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output int cnt);
    cnt = 0;
    while (!out_valid && cnt < max) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    // reset with data already waiting
    for (int i = 1; i <= 4; i++) push(16'(i));
    step(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_rd_en", fifo_rd_en, 0);

    // 1: fill
    rst = 1'b0;
    #1 chk("fill_rd0", fifo_rd_en, 1);
    wait_valid(12, n);
    chk("fill_lat", n, 5);
    chk("fill_valid", out_valid, 1);
    chk("fill_data", out_data, 64'h0004_0003_0002_0001);
    chk("fill_keep", out_keep, 4'hF);
    step(1);
    chk("fill_done", out_valid, 0);
    chk("fill_clr", out_data, 0);

    // 2: partial flush
    push(16'hA0A0); push(16'hB1B1); push(16'hC2C2);
    step(5);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("pf_n1", out_valid, 0);
    step(1);
    chk("pf_n2", out_valid, 1);
    chk("pf_keep", out_keep, 4'b0111);
    chk("pf_data", out_data, 64'h0000_C2C2_B1B1_A0A0);
    step(1);

    // 3: empty flush
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    bad = 0;
    repeat (5) begin
      if (out_valid || fifo_rd_en) bad++;
      step(1);
    end
    chk("ef_idle", bad, 0);

    // 4: backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'h1000 + 16'(i));
    wait_valid(12, n);
    chk("bp_valid", out_valid, 1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_data !== 64'h1004_1003_1002_1001 || fifo_rd_en || !out_valid)
        bad++;
    end
    chk("bp_stable", bad, 0);
    out_ready = 1'b1;
    #1 chk("bp_overlap", fifo_rd_en, 1);
    step(1);
    chk("bp_xfer", out_valid, 0);
    wait_valid(12, n);
    chk("bp_lat2", n, 4);
    chk("bp_data2", out_data, 64'h1008_1007_1006_1005);
    step(1);

    // 5: reset mid-collection
    for (int i = 1; i <= 4; i++) push(16'h5000 + 16'(i));
    #1 chk("mr_rd0", fifo_rd_en, 1);
    step(3);
    chk("mr_pre", out_data, 64'h0000_0000_5002_5001);
    rst = 1'b1;
    #1;
    chk("mr_data", out_data, 0);
    chk("mr_keep", out_keep, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_rd_en", fifo_rd_en, 0);
    step(2);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) push(16'h6000 + 16'(i));
    wait_valid(12, n);
    chk("mr_lat", n, 5);
    chk("mr_beat", out_data, 64'h6003_6002_6001_5004);
    step(1);

    // 6: throughput and stats
    rst = 1'b1;
    step(1);
    rst = 1'b0;
`ifdef FIFO_WORD_PACKER_STATS_EN
    chk("st_rst_b", beat_count, 0);
    chk("st_rst_p", partial_count, 0);
`endif
    for (int i = 1; i <= 12; i++) push(16'h7000 + 16'(i));
    wait_valid(12, n);
    chk("tp_lat1", n, 5);
    chk("tp_data1", out_data, 64'h7004_7003_7002_7001);
    step(1);
    wait_valid(12, n);
    chk("tp_lat2", n, 4);
    chk("tp_data2", out_data, 64'h7008_7007_7006_7005);
    step(1);
    wait_valid(12, n);
    chk("tp_lat3", n, 4);
    chk("tp_data3", out_data, 64'h700C_700B_700A_7009);
    step(1);
    push(16'h8001); push(16'h8002);
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_valid(4, n);
    chk("fl_lat", n, 1);
    chk("fl_keep", out_keep, 4'b0011);
    chk("fl_data", out_data, 64'h0000_0000_8002_8001);
    step(1);
`ifdef FIFO_WORD_PACKER_STATS_EN
    chk("st_beats", beat_count, 4);
    chk("st_partial", partial_count, 1);
`endif

    chk("no_underflow", underflow, 0);
    chk("fifo_drained", wr_ptr - rd_ptr, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
